// File: rtl/rv32i_ctrl_fsm_if.sv
// Fetch and data-memory handshake between the control sequencer and its
// neighbours.
//   instr_req   : sequencer asks for the next instruction (FETCH)
//   instr_valid : instruction word on `instr` is valid
//   instr       : 32-bit instruction word
//   mem_re/we   : data-memory read/write request, held while waiting
//   mem_ready   : data-memory access complete
// master = the sequencer, slave = instruction/data memory side.
interface rv32i_ctrl_fsm_if;
    logic        instr_req;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready;

    modport master (
        output instr_req, mem_re, mem_we,
        input  instr_valid, instr, mem_ready
    );

    modport slave (
        input  instr_req, mem_re, mem_we,
        output instr_valid, instr, mem_ready
    );
endinterface

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer and decoder for the RV32I core.
// Walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> WRITEBACK and drives the
// register-file, data-memory and PC strobes. Every output is a flop.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : fetch / data-memory handshake (master side)
//   alu_result0   : ALU result bit 0, used as the branch condition
//   alu_control   : ALU op code; imm_val, shamt, rs1, rs2, rd : decode fields
//   src1_pc       : ALU src1 takes the PC (JAL)
//   reg_we, pc_en, pc_sel : write-back strobes
//   illegal       : sticky illegal-instruction flag, cleared only by reset
module rv32i_ctrl_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_ctrl_fsm_if.master     bus,
    input  logic                 alu_result0,
    output logic [5:0]           alu_control,
    output logic [31:0]          imm_val,
    output logic [4:0]           shamt,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic                 src1_pc,
    output logic                 reg_we,
    output logic                 pc_en,
    output logic                 pc_sel,
    output logic                 illegal
);
    // States are numbered upward from RESET_STATE so FETCH keeps that code.
    typedef enum logic [2:0] {
        S_FETCH     = RESET_STATE,
        S_DECODE    = 3'(RESET_STATE + 3'd1),
        S_EXECUTE   = 3'(RESET_STATE + 3'd2),
        S_MEMORY    = 3'(RESET_STATE + 3'd3),
        S_WRITEBACK = 3'(RESET_STATE + 3'd4)
    } state_t;

    // Instruction class latched with the decode fields; steers later states.
    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_JAL, C_ILL
    } cls_t;

    state_t state, state_nxt;
    cls_t   cls, d_cls;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, d_imm;
    logic [5:0]  d_ctrl;
    logic        d_src1_pc, accept;
    logic        instr_req_nxt, mem_re_nxt, mem_we_nxt;
    logic        pc_en_nxt, reg_we_nxt, pc_sel_nxt;

    assign opc   = bus.instr[6:0];
    assign f3    = bus.instr[14:12];
    assign f7    = bus.instr[31:25];
    assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                    bus.instr[11:8], 1'b0};
    assign imm_j = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                    bus.instr[30:21], 1'b0};
    assign imm_u = {bus.instr[31:12], 12'h000};

    assign accept = (state == S_FETCH) && bus.instr_valid;

    // Decode of the incoming word; anything not matched stays C_ILL / 0.
    always_comb begin
        d_cls     = C_ILL;
        d_ctrl    = 6'h00;
        d_imm     = 32'h0;
        d_src1_pc = 1'b0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    d_cls = C_ALU;
                    case (f3)
                        3'd0:    d_ctrl = 6'h01;
                        3'd1:    d_ctrl = 6'h03;
                        3'd2:    d_ctrl = 6'h04;
                        3'd3:    d_ctrl = 6'h05;
                        3'd4:    d_ctrl = 6'h06;
                        3'd5:    d_ctrl = 6'h07;
                        3'd6:    d_ctrl = 6'h09;
                        default: d_ctrl = 6'h0A;
                    endcase
                end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    d_cls  = C_ALU;
                    d_ctrl = (f3 == 3'd0) ? 6'h02 : 6'h08;
                end
            end
            7'b0010011: begin
                // Shift-immediates need funct7 = 0; SRAI is not supported.
                if (!((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00)) begin
                    d_cls = C_ALU;
                    d_imm = imm_i;
                    case (f3)
                        3'd0:    d_ctrl = 6'h0B;
                        3'd1:    d_ctrl = 6'h0C;
                        3'd2:    d_ctrl = 6'h0D;
                        3'd3:    d_ctrl = 6'h0E;
                        3'd4:    d_ctrl = 6'h0F;
                        3'd5:    d_ctrl = 6'h10;
                        3'd6:    d_ctrl = 6'h11;
                        default: d_ctrl = 6'h12;
                    endcase
                end
            end
            7'b0000011: if (f3 == 3'd0 || f3 == 3'd2) begin
                d_cls  = C_LOAD;
                d_imm  = imm_i;
                d_ctrl = (f3 == 3'd0) ? 6'h13 : 6'h15;
            end
            7'b0100011: if (f3 == 3'd0 || f3 == 3'd2) begin
                d_cls  = C_STORE;
                d_imm  = imm_s;
                d_ctrl = (f3 == 3'd0) ? 6'h18 : 6'h1A;
            end
            7'b1100011: if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) begin
                d_cls = C_BRANCH;
                d_imm = imm_b;
                case (f3)
                    3'd0:    d_ctrl = 6'h1B;
                    3'd1:    d_ctrl = 6'h1C;
                    3'd4:    d_ctrl = 6'h20;
                    default: d_ctrl = 6'h1F;
                endcase
            end
            7'b0110111: begin
                d_cls  = C_LUI;
                d_ctrl = 6'h21;
                d_imm  = imm_u;
            end
            7'b1101111: begin
                d_cls     = C_JAL;
                d_ctrl    = 6'h22;
                d_imm     = imm_j;
                d_src1_pc = 1'b1;
            end
            default: ;
        endcase
    end

    // Next state plus the strobes for the state being entered, so the
    // registered strobes line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:     if (bus.instr_valid) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = (cls == C_ILL) ? S_FETCH : S_EXECUTE;
            S_EXECUTE:   state_nxt = (cls == C_LOAD || cls == C_STORE) ? S_MEMORY
                                                                       : S_WRITEBACK;
            S_MEMORY:    if (bus.mem_ready) state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            default:     state_nxt = S_FETCH;
        endcase

        instr_req_nxt = (state_nxt == S_FETCH);
        mem_re_nxt    = (state_nxt == S_MEMORY) && (cls == C_LOAD);
        mem_we_nxt    = (state_nxt == S_MEMORY) && (cls == C_STORE);
        pc_en_nxt     = (state_nxt == S_WRITEBACK);
        reg_we_nxt    = pc_en_nxt && (rd != 5'd0) &&
                        (cls inside {C_ALU, C_LOAD, C_LUI, C_JAL});
        // Branches reach WRITEBACK only from EXECUTE, so the branch_taken
        // sample is taken on that edge and held in pc_sel itself.
        pc_sel_nxt    = pc_en_nxt &&
                        (cls == C_JAL || (cls == C_BRANCH && alu_result0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instr_req <= 1'b1;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            pc_en         <= 1'b0;
            reg_we        <= 1'b0;
            pc_sel        <= 1'b0;
            cls           <= C_NONE;
            alu_control   <= 6'h00;
            imm_val       <= 32'h0;
            shamt         <= 5'd0;
            rs1           <= 5'd0;
            rs2           <= 5'd0;
            rd            <= 5'd0;
            src1_pc       <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            bus.instr_req <= instr_req_nxt;
            bus.mem_re    <= mem_re_nxt;
            bus.mem_we    <= mem_we_nxt;
            pc_en         <= pc_en_nxt;
            reg_we        <= reg_we_nxt;
            pc_sel        <= pc_sel_nxt;
            if (accept) begin
                cls         <= d_cls;
                alu_control <= d_ctrl;
                imm_val     <= d_imm;
                shamt       <= bus.instr[24:20];
                rs1         <= bus.instr[19:15];
                rs2         <= bus.instr[24:20];
                rd          <= bus.instr[11:7];
                src1_pc     <= d_src1_pc;
                illegal     <= illegal | (d_cls == C_ILL);
            end
        end
    end
endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
module tb_rv32i_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_result0 = 1'b0;
    logic [5:0]  alu_control;
    logic [31:0] imm_val;
    logic [4:0]  shamt, rs1, rs2, rd;
    logic        src1_pc, reg_we, pc_en, pc_sel, illegal;

    rv32i_ctrl_fsm_if bus();

    rv32i_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .alu_result0(alu_result0),
        .alu_control(alu_control), .imm_val(imm_val), .shamt(shamt),
        .rs1(rs1), .rs2(rs2), .rd(rd), .src1_pc(src1_pc), .reg_we(reg_we),
        .pc_en(pc_en), .pc_sel(pc_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          ill_model = 1'b0;
    logic [31:0] cur_ins = 32'h0;

    // Legal encodings: opcode, funct3 (-1 any), funct7 (-1 any), op code.
    typedef struct packed { int opc; int f3; int f7; int code; } dent_t;
    dent_t dtab [28];

    typedef struct packed {
        logic [5:0] ctrl; logic [31:0] imm; logic [4:0] rs1, rs2, rd, shamt;
        logic src1, ill, stable, tmo, psel; int lat, mre, mwe, rwe, pce;
    } obs_t;

    typedef struct packed {
        logic legal; logic [5:0] ctrl; logic [31:0] imm;
        int lat, mre, mwe, rwe, pce; logic psel, src1;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins; logic ares; int n; logic [5:0] ctrl; logic [31:0] imm;
        logic [4:0] rd; int lat; logic rwe, psel, ill;
    } vec_t;
    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s instr=%h: got %h, want %h", name, cur_ins, act, exp);
        end
    endtask

    // Reference: table lookup for the op code, arithmetic for immediates,
    // timing from the per-class cycle counts.
    function automatic exp_t model(input logic [31:0] ins, input bit ares, input int n);
        exp_t e;
        int opc, f3, f7, s;
        e   = '0;
        opc = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        for (int i = 0; i < 28; i++)
            if (dtab[i].opc == opc && (dtab[i].f3 < 0 || dtab[i].f3 == f3) &&
                (dtab[i].f7 < 0 || dtab[i].f7 == f7)) begin
                e.legal = 1'b1;
                e.ctrl  = 6'(dtab[i].code);
            end
        s = $signed(ins);
        case (opc)
            'h13, 'h03: e.imm = s >>> 20;
            'h23: e.imm = (s >>> 25) * 32 + int'(ins[11:7]);
            'h63: e.imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                          int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            'h6F: e.imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 +
                          int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            'h37: e.imm = ins & 32'hFFFFF000;
            default: e.imm = 0;
        endcase
        if (!e.legal)                        e.lat = 2;
        else if (opc == 'h03 || opc == 'h23) e.lat = 4 + n;
        else                                 e.lat = 4;
        e.mre  = (e.legal && opc == 'h03) ? n : 0;
        e.mwe  = (e.legal && opc == 'h23) ? n : 0;
        e.pce  = e.legal ? 1 : 0;
        e.rwe  = (e.legal && (opc == 'h33 || opc == 'h13 || opc == 'h03 ||
                  opc == 'h37 || opc == 'h6F) && ins[11:7] != 5'd0) ? 1 : 0;
        e.psel = e.legal && (opc == 'h6F || (opc == 'h63 && ares));
        e.src1 = e.legal && opc == 'h6F;
        return e;
    endfunction

    // Issue one instruction and watch every cycle until the next instr_req.
    // The memory side completes on the n-th MEMORY cycle.
    task automatic run_instr(input logic [31:0] ins, input bit ares, input int n,
                             output obs_t o);
        int k, mc;
        o = '0;
        cur_ins = ins;
        k = 0;
        while (!bus.instr_req && k < 20) begin @(posedge clk); #1; k++; end
        bus.instr = ins; bus.instr_valid = 1'b1; bus.mem_ready = 1'b0;
        alu_result0 = ares;
        @(posedge clk); #1;
        k = 1; mc = 0;
        o.ctrl = alu_control; o.imm = imm_val; o.rs1 = rs1; o.rs2 = rs2;
        o.rd = rd; o.shamt = shamt; o.src1 = src1_pc; o.stable = 1'b1;
        while (k < 64) begin
            if ({alu_control, imm_val, rs1, rs2, rd, shamt, src1_pc} !==
                {o.ctrl, o.imm, o.rs1, o.rs2, o.rd, o.shamt, o.src1}) o.stable = 1'b0;
            if (bus.mem_re) o.mre++;
            if (bus.mem_we) o.mwe++;
            if (reg_we)     o.rwe++;
            if (pc_en)      o.pce++;
            o.psel |= pc_sel;
            if (bus.instr_req) break;
            if (bus.mem_re || bus.mem_we) mc++;
            bus.mem_ready   = (mc >= n);
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.instr       = $urandom;
            @(posedge clk); #1;
            k++;
        end
        o.tmo = !bus.instr_req;
        o.lat = k;
        o.ill = illegal;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    task automatic check_vs_model(input logic [31:0] ins, input bit ares, input int n,
                                  input obs_t o);
        exp_t e;
        e = model(ins, ares, n);
        if (!e.legal) ill_model = 1'b1;
        check("timeout", 32'(o.tmo), 0);
        check("alu_control", 32'(o.ctrl), 32'(e.ctrl));
        if (e.legal) check("imm_val", o.imm, e.imm);
        check("rs1", 32'(o.rs1), 32'(ins[19:15]));
        check("rs2", 32'(o.rs2), 32'(ins[24:20]));
        check("rd", 32'(o.rd), 32'(ins[11:7]));
        check("shamt", 32'(o.shamt), 32'(ins[24:20]));
        check("src1_pc", 32'(o.src1), 32'(e.src1));
        check("illegal", 32'(o.ill), 32'(ill_model));
        check("decode_stable", 32'(o.stable), 1);
        check("latency", o.lat, e.lat);
        check("mem_re_cycles", o.mre, e.mre);
        check("mem_we_cycles", o.mwe, e.mwe);
        check("reg_we_cycles", o.rwe, e.rwe);
        check("pc_en_cycles", o.pce, e.pce);
        check("pc_sel", 32'(o.psel), 32'(e.psel));
    endtask

    logic [6:0] opcs [11];

    initial begin
        obs_t        o;
        logic [31:0] ins;
        int          sel, k;
        bit          bad;

        dtab = '{
            '{'h33,0,'h00,'h01}, '{'h33,0,'h20,'h02}, '{'h33,1,'h00,'h03},
            '{'h33,2,'h00,'h04}, '{'h33,3,'h00,'h05}, '{'h33,4,'h00,'h06},
            '{'h33,5,'h00,'h07}, '{'h33,5,'h20,'h08}, '{'h33,6,'h00,'h09},
            '{'h33,7,'h00,'h0A},
            '{'h13,0,-1,'h0B}, '{'h13,1,'h00,'h0C}, '{'h13,2,-1,'h0D},
            '{'h13,3,-1,'h0E}, '{'h13,4,-1,'h0F}, '{'h13,5,'h00,'h10},
            '{'h13,6,-1,'h11}, '{'h13,7,-1,'h12},
            '{'h03,0,-1,'h13}, '{'h03,2,-1,'h15},
            '{'h23,0,-1,'h18}, '{'h23,2,-1,'h1A},
            '{'h63,0,-1,'h1B}, '{'h63,1,-1,'h1C}, '{'h63,5,-1,'h1F},
            '{'h63,4,-1,'h20},
            '{'h37,-1,-1,'h21}, '{'h6F,-1,-1,'h22}
        };

        // ins, alu_result0, mem cycles, ctrl, imm, rd, latency, reg_we, pc_sel, illegal
        vt = '{
            '{32'h00500093, 1'b0, 1, 6'h0B, 32'h5,        5'd1,  4, 1'b1, 1'b0, 1'b0},
            '{32'h402081B3, 1'b0, 1, 6'h02, 32'h0,        5'd3,  4, 1'b1, 1'b0, 1'b0},
            '{32'h002081B3, 1'b0, 1, 6'h01, 32'h0,        5'd3,  4, 1'b1, 1'b0, 1'b0},
            '{32'h0080A283, 1'b0, 3, 6'h15, 32'h8,        5'd5,  7, 1'b1, 1'b0, 1'b0},
            '{32'h0050A623, 1'b0, 1, 6'h1A, 32'hC,        5'd12, 5, 1'b0, 1'b0, 1'b0},
            '{32'h00208463, 1'b1, 1, 6'h1B, 32'h8,        5'd8,  4, 1'b0, 1'b1, 1'b0},
            '{32'h00208463, 1'b0, 1, 6'h1B, 32'h8,        5'd8,  4, 1'b0, 1'b0, 1'b0},
            '{32'h123450B7, 1'b0, 1, 6'h21, 32'h12345000, 5'd1,  4, 1'b1, 1'b0, 1'b0},
            '{32'hFFDFF0EF, 1'b0, 1, 6'h22, 32'hFFFFFFFC, 5'd1,  4, 1'b1, 1'b1, 1'b0},
            '{32'h00000013, 1'b0, 1, 6'h0B, 32'h0,        5'd0,  4, 1'b0, 1'b0, 1'b0},
            '{32'hFFFFFFFF, 1'b0, 1, 6'h00, 32'h0,        5'd31, 2, 1'b0, 1'b0, 1'b1},
            '{32'h00500093, 1'b0, 1, 6'h0B, 32'h5,        5'd1,  4, 1'b1, 1'b0, 1'b1},
            '{32'h4010D093, 1'b1, 1, 6'h00, 32'h0,        5'd1,  2, 1'b0, 1'b0, 1'b1}
        };

        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F,
                 7'h17, 7'h67, 7'h73, 7'h0F};

        bus.instr_valid = 1'b0; bus.instr = 32'h0; bus.mem_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_req", 32'(bus.instr_req), 1);
        check("rst_mem_req", 32'({bus.mem_re, bus.mem_we}), 0);
        check("rst_alu_control", 32'(alu_control), 0);
        check("rst_imm_val", imm_val, 0);
        check("rst_fields", 32'({rs1, rs2, rd, shamt}), 0);
        check("rst_strobes", 32'({reg_we, pc_en, pc_sel, src1_pc, illegal}), 0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_instr(vt[i].ins, vt[i].ares, vt[i].n, o);
            check("vec_ctrl", 32'(o.ctrl), 32'(vt[i].ctrl));
            if (vt[i].ctrl != 6'h00) check("vec_imm", o.imm, vt[i].imm);
            check("vec_rd", 32'(o.rd), 32'(vt[i].rd));
            check("vec_latency", o.lat, vt[i].lat);
            check("vec_reg_we", 32'(o.rwe), 32'(vt[i].rwe));
            check("vec_pc_sel", 32'(o.psel), 32'(vt[i].psel));
            check("vec_illegal", 32'(o.ill), 32'(vt[i].ill));
            check_vs_model(vt[i].ins, vt[i].ares, vt[i].n, o);
        end

        // Reset in the middle of a load that never completes
        cur_ins = 32'h0080A283;
        bus.instr = 32'h0080A283; bus.instr_valid = 1'b1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        k = 0;
        while (!bus.mem_re && k < 10) begin @(posedge clk); #1; k++; end
        check("mid_mem_re_up", 32'(bus.mem_re), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_re", 32'(bus.mem_re), 0);
        check("midrst_instr_req", 32'(bus.instr_req), 1);
        check("midrst_illegal", 32'(illegal), 0);
        check("midrst_alu_control", 32'(alu_control), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        ill_model = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (reg_we || pc_en || bus.mem_re || !bus.instr_req) bad = 1'b1;
        end
        check("midrst_no_writeback", 32'(bad), 0);

        // Randomized instructions against the reference model
        for (int i = 0; i < 160; i++) begin
            ins = $urandom;
            sel = $urandom_range(0, 11);
            if (sel < 11) begin
                ins[6:0] = opcs[sel];
                if ((sel < 2) && $urandom_range(0, 3) != 0)
                    ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(1, 4), o);
            check_vs_model(ins, alu_result0, o.mre + o.mwe > 0 ? o.mre + o.mwe : 1, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_ctrl_fsm.md
Name: rv32i_ctrl_fsm

Overview:
Multi-cycle control sequencer and instruction decoder for the RV32I core; it produces the ALU's operation code and operands.
- Accepts a 32-bit instruction from the fetch interface and decodes it into `alu_control[5:0]`, the immediate, the shift amount and register addresses.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the register-file, data-memory and PC strobes.
- Sits between instruction memory, register file, ALU, data memory and the PC register.

Parameters:
- `RESET_STATE`, 3'd0, encoding of FETCH, the state entered on reset.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `instr_req`  output  1  request next instruction; high while in FETCH.
- `instr_valid`  input  1  `instr` valid this cycle; sampled only in FETCH.
- `instr`  input  32  instruction word.
- `alu_result0`  input  1  bit 0 of the ALU result; this is the branch condition.
- `mem_ready`  input  1  data-memory access complete.
- `alu_control`  output  6  ALU operation code (encoding below).
- `imm_val`  output  32  sign-extended immediate; for LUI, `{instr[31:12],12'b0}`.
- `shamt`  output  5  `instr[24:20]`.
- `rs1`, `rs2`, `rd`  output  5 each  register addresses.
- `src1_pc`  output  1  ALU src1 selects PC instead of `rs1` data (JAL).
- `reg_we`  output  1  register-file write strobe.
- `mem_re`, `mem_we`  output  1 each  data-memory read/write request.
- `pc_en`  output  1  PC update strobe.
- `pc_sel`  output  1  0 = PC+4, 1 = PC+`imm_val`.
- `illegal`  output  1  sticky illegal-instruction flag.

Behaviour:
- **Reset** (`rst_n` low, asynchronous):
  - State = FETCH.
  - All outputs 0 except `instr_req` = 1.
  - Latched instruction = 0.
  - `illegal` = 0.
- **Reset mid-operation:** any pending memory request is dropped immediately; there is no write-back.
- **All outputs are registered.** Decode fields change only on the FETCH→DECODE edge.
- **FETCH:** `instr_req` = 1. On `instr_valid`, latch `instr` and go to DECODE. `instr_valid` is ignored in every other state.
- **DECODE (1 cycle):** register `alu_control`, `imm_val`, `shamt`, `rs1`/`rs2`/`rd` and `src1_pc`, then go to EXECUTE.
  - Illegal opcode or funct: `alu_control` = 0, `illegal` set, return to FETCH. PC is not advanced.
- **EXECUTE (1 cycle):**
  - Loads/stores go to MEMORY.
  - All other instructions go to WRITEBACK.
  - Branches register `branch_taken` = `alu_result0` on this edge.
- **MEMORY:**
  - Loads hold `mem_re` = 1; stores hold `mem_we` = 1.
  - Wait for `mem_ready`. If `mem_ready` is already high on the entry cycle, exit the next cycle (minimum 1 cycle).
  - Then go to WRITEBACK.
- **WRITEBACK (1 cycle):**
  - `pc_en` = 1.
  - `reg_we` = 1 for ALU, LUI, JAL and load instructions, and only when `rd` ≠ 0.
  - `pc_sel` = 1 for JAL, and for branches when `branch_taken` = 1; otherwise 0.
  - Next state is FETCH.
- **Latency:**
  - ALU/branch instruction: 4 cycles from `instr_valid` to the next `instr_req`.
  - Load/store: 5 + memory-wait cycles.
- **`alu_control` encoding (hex):**
  - R-type: ADD 01, SUB 02, SLL 03, SLT 04, SLTU 05, XOR 06, SRL 07, SRA 08, OR 09, AND 0A.
  - I-type: ADDI 0B, SLLI 0C, SLTI 0D, SLTIU 0E, XORI 0F, SRLI 10, ORI 11, ANDI 12.
  - Loads/stores: LB 13, LW 15, SB 18, SW 1A.
  - Branches: BEQ 1B, BNE 1C, BGE 1F, BLT 20.
  - Other: LUI 21, JAL 22 (sets `src1_pc` = 1).
- **Illegal set:** SRAI, LH/LBU/LHU, SH, BLTU/BGEU, AUIPC, JALR, SYSTEM/FENCE, and any bad funct7 on R-type.
- **Immediates:**
  - I-type: `instr[31:20]` sign-extended.
  - S-type: `{instr[31:25], instr[11:7]}` sign-extended.
  - B-type: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}` sign-extended.
  - J-type: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}` sign-extended.
- **`illegal`:** cleared only by reset.

Test Plan:
1. Reset mid-MEMORY with `mem_re` = 1 → `mem_re` drops the same cycle; state FETCH; `instr_req` = 1.
2. `instr` = 0x00500093 (`addi x1,x0,5`) → `alu_control` = 0x0B, `imm_val` = 5, `rd` = 1. WRITEBACK shows `reg_we` = 1 and `pc_en` = 1, `pc_sel` = 0. Next `instr_req` comes 4 cycles after `instr_valid`.
3. `instr` = 0x402081B3 (`sub x3,x1,x2`) → `alu_control` = 0x02, `rs1` = 1, `rs2` = 2, `rd` = 3. 0x002081B3 gives 0x01.
4. `instr` = 0x0080A283 (`lw x5,8(x1)`) with `mem_ready` delayed 3 cycles → `alu_control` = 0x15, `mem_re` held 3 cycles, then `reg_we` = 1 to `rd` = 5. `instr` = 0x0050A623 (`sw`) gives `imm_val` = 12, `mem_we` = 1, `reg_we` = 0.
5. `instr` = 0x00208463 (`beq x1,x2,+8`) → `alu_control` = 0x1B, `imm_val` = 8. With `alu_result0` = 1: `pc_sel` = 1, `reg_we` = 0. With `alu_result0` = 0: `pc_sel` = 0.
6. `instr` = 0xFFFFFFFF → `illegal` = 1, `alu_control` = 0, no `pc_en` or `reg_we`, return to FETCH. `illegal` stays set across the next legal instruction.
